// File: rtl/cpu_pkg.sv
// Shared CPU constants: forwarding-source encoding, ALU opcodes, link register.
// Pure definitions; no logic.
package cpu_pkg;

  localparam logic [1:0] FWD_RF   = 2'b00;
  localparam logic [1:0] FWD_EX   = 2'b01;
  localparam logic [1:0] FWD_MEM  = 2'b10;
  localparam logic [1:0] FWD_LOAD = 2'b11;

  // Encoding of the downstream ALU's aluc input.
  localparam logic [3:0] ADD = 4'b0000;
  localparam logic [3:0] SUB = 4'b0100;
  localparam logic [3:0] AND = 4'b0001;
  localparam logic [3:0] OR  = 4'b0101;
  localparam logic [3:0] XOR = 4'b0010;
  localparam logic [3:0] LUI = 4'b0110;
  localparam logic [3:0] SLL = 4'b0011;
  localparam logic [3:0] SRL = 4'b0111;
  localparam logic [3:0] SRA = 4'b1111;

  localparam int REG_RA = 31;

endpackage

// File: rtl/fwd_mux4.sv
// 4:1 operand forwarding mux: register file, EX result, MEM ALU result, MEM load data.
// Purely combinational, no flow control.
module fwd_mux4
  import cpu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [1:0]      sel,
  input  logic [XLEN-1:0] d_rf,
  input  logic [XLEN-1:0] d_ex,
  input  logic [XLEN-1:0] d_mem,
  input  logic [XLEN-1:0] d_load,
  output logic [XLEN-1:0] y
);

  always_comb begin
    y = d_rf;
    case (sel)
      FWD_RF:   y = d_rf;
      FWD_EX:   y = d_ex;
      FWD_MEM:  y = d_mem;
      FWD_LOAD: y = d_load;
      default:  y = d_rf;
    endcase
  end

endmodule

// File: rtl/pipe_id_ex.sv
// ID/EX pipeline register feeding the ALU; ex_result is valid in the same EX cycle.
// One cycle ID->EX; hold freezes every field, flush loads a bubble that never writes state.
module pipe_id_ex
  import cpu_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int RW   = 5
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            hold,
  input  logic            flush,
  input  logic [XLEN-1:0] id_qa,
  input  logic [XLEN-1:0] id_qb,
  input  logic [1:0]      id_fwda,
  input  logic [1:0]      id_fwdb,
  input  logic [XLEN-1:0] mem_alu,
  input  logic [XLEN-1:0] mem_load,
  input  logic [XLEN-1:0] id_imm,
  input  logic [XLEN-1:0] id_pc4,
  input  logic [3:0]      id_aluc,
  input  logic            id_aluimm,
  input  logic            id_shift,
  input  logic            id_jal,
  input  logic            id_wreg,
  input  logic            id_m2reg,
  input  logic            id_wmem,
  input  logic [RW-1:0]   id_rn,
  input  logic [XLEN-1:0] alu_s,
  output logic [XLEN-1:0] alu_a,
  output logic [XLEN-1:0] alu_b,
  output logic [3:0]      alu_aluc,
  output logic [XLEN-1:0] ex_result,
  output logic            ex_wreg,
  output logic            ex_m2reg,
  output logic            ex_wmem,
  output logic [RW-1:0]   ex_rn,
  output logic [XLEN-1:0] ex_eb,
  output logic            ex_valid
);

  typedef struct packed {
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] pc4;
    logic [3:0]      aluc;
    logic            shift;
    logic            aluimm;
    logic            jal;
    logic            wreg;
    logic            m2reg;
    logic            wmem;
    logic [RW-1:0]   rn;
    logic            valid;
  } ex_reg_t;

  ex_reg_t         e_q;
  ex_reg_t         id_d;
  logic [XLEN-1:0] fa;
  logic [XLEN-1:0] fb;

  fwd_mux4 #(.XLEN(XLEN)) u_fwda (
    .sel    (id_fwda),
    .d_rf   (id_qa),
    .d_ex   (ex_result),
    .d_mem  (mem_alu),
    .d_load (mem_load),
    .y      (fa)
  );

  fwd_mux4 #(.XLEN(XLEN)) u_fwdb (
    .sel    (id_fwdb),
    .d_rf   (id_qb),
    .d_ex   (ex_result),
    .d_mem  (mem_alu),
    .d_load (mem_load),
    .y      (fb)
  );

  // A bubble keeps the ID data fields but drops every side effect.
  always_comb begin
    id_d        = '0;
    id_d.a      = fa;
    id_d.b      = fb;
    id_d.imm    = id_imm;
    id_d.pc4    = id_pc4;
    id_d.aluc   = id_aluc;
    id_d.shift  = id_shift;
    id_d.aluimm = id_aluimm;
    id_d.rn     = id_rn;
    id_d.jal    = id_jal   & ~flush;
    id_d.wreg   = id_wreg  & ~flush;
    id_d.m2reg  = id_m2reg & ~flush;
    id_d.wmem   = id_wmem  & ~flush;
    id_d.valid  = ~flush;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      e_q <= '0;
    end else if (!hold) begin
      e_q <= id_d;
    end
  end

  assign alu_a     = e_q.shift  ? {{(XLEN-5){1'b0}}, e_q.imm[10:6]} : e_q.a;
  assign alu_b     = e_q.aluimm ? e_q.imm : e_q.b;
  assign alu_aluc  = e_q.aluc;
  assign ex_result = e_q.jal ? e_q.pc4 + XLEN'(4) : alu_s;
  assign ex_rn     = e_q.jal ? RW'(REG_RA) : e_q.rn;
  assign ex_eb     = e_q.b;
  assign ex_wreg   = e_q.wreg;
  assign ex_m2reg  = e_q.m2reg;
  assign ex_wmem   = e_q.wmem;
  assign ex_valid  = e_q.valid;

endmodule

// File: tb/tb_pipe_id_ex.sv
// Bench for pipe_id_ex: directed table, hand-written hold/flush/reset sequences, random run vs model.
// A behavioural ALU closes the alu_a/alu_b/alu_aluc -> alu_s loop.
module tb_pipe_id_ex;
  import cpu_pkg::*;

  logic        clock, reset, hold, flush;
  logic [31:0] id_qa, id_qb, mem_alu, mem_load, id_imm, id_pc4, alu_s;
  logic [1:0]  id_fwda, id_fwdb;
  logic [3:0]  id_aluc;
  logic        id_aluimm, id_shift, id_jal, id_wreg, id_m2reg, id_wmem;
  logic [4:0]  id_rn;
  logic [31:0] alu_a, alu_b, ex_result, ex_eb;
  logic [3:0]  alu_aluc;
  logic        ex_wreg, ex_m2reg, ex_wmem, ex_valid;
  logic [4:0]  ex_rn;

  pipe_id_ex #(.XLEN(32), .RW(5)) dut (
    .clock(clock), .reset(reset), .hold(hold), .flush(flush),
    .id_qa(id_qa), .id_qb(id_qb), .id_fwda(id_fwda), .id_fwdb(id_fwdb),
    .mem_alu(mem_alu), .mem_load(mem_load), .id_imm(id_imm), .id_pc4(id_pc4),
    .id_aluc(id_aluc), .id_aluimm(id_aluimm), .id_shift(id_shift), .id_jal(id_jal),
    .id_wreg(id_wreg), .id_m2reg(id_m2reg), .id_wmem(id_wmem), .id_rn(id_rn),
    .alu_s(alu_s), .alu_a(alu_a), .alu_b(alu_b), .alu_aluc(alu_aluc),
    .ex_result(ex_result), .ex_wreg(ex_wreg), .ex_m2reg(ex_m2reg), .ex_wmem(ex_wmem),
    .ex_rn(ex_rn), .ex_eb(ex_eb), .ex_valid(ex_valid)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [31:0] alu_fn(input logic [31:0] a, input logic [31:0] b,
                                         input logic [3:0] c);
    logic signed [31:0] sb;
    sb = b;
    case (c)
      ADD:     return a + b;
      SUB:     return a - b;
      AND:     return a & b;
      OR:      return a | b;
      XOR:     return a ^ b;
      LUI:     return {b[15:0], 16'h0000};
      SLL:     return b << a[4:0];
      SRL:     return b >> a[4:0];
      SRA:     return sb >>> a[4:0];
      default: return a + b;
    endcase
  endfunction

  always_comb alu_s = alu_fn(alu_a, alu_b, alu_aluc);

  typedef struct {
    logic        hold, flush;
    logic [31:0] qa, qb, imm, pc4, malu, mload;
    logic [1:0]  fwda, fwdb;
    logic [3:0]  aluc;
    logic        aluimm, shift, jal, wreg, m2reg, wmem;
    logic [4:0]  rn;
  } in_t;

  typedef struct {
    in_t         i;
    logic [31:0] x_a, x_b, x_res;
    logic [4:0]  x_rn;
    logic        x_wreg;
  } vec_t;

  // Model: the instruction currently sitting in EX, as the ID side presented it.
  typedef struct {
    logic [31:0] a, b, imm, pc4;
    logic [3:0]  aluc;
    logic        shift, aluimm, jal, wreg, m2reg, wmem, valid;
    logic [4:0]  rn;
  } m_t;

  m_t m;
  int n_vec = 0;
  int n_bad = 0;
  logic [3:0] ops [9] = '{ADD, SUB, AND, OR, XOR, LUI, SLL, SRL, SRA};

  function automatic in_t zero_in();
    in_t r;
    r = '{default: '0};
    return r;
  endfunction

  function automatic vec_t mkv(input in_t i, input logic [31:0] a, input logic [31:0] b,
                               input logic [31:0] res, input logic [4:0] rn, input logic wr);
    vec_t v;
    v.i = i; v.x_a = a; v.x_b = b; v.x_res = res; v.x_rn = rn; v.x_wreg = wr;
    return v;
  endfunction

  function automatic logic [31:0] m_opa();
    return m.shift ? {27'b0, m.imm[10:6]} : m.a;
  endfunction

  function automatic logic [31:0] m_opb();
    return m.aluimm ? m.imm : m.b;
  endfunction

  function automatic logic [31:0] m_res();
    return m.jal ? m.pc4 + 32'd4 : alu_fn(m_opa(), m_opb(), m.aluc);
  endfunction

  function automatic logic [31:0] pick(input logic [1:0] sel, input logic [31:0] rf,
                                       input logic [31:0] ma, input logic [31:0] ml);
    case (sel)
      2'd0:    return rf;
      2'd1:    return m_res();
      2'd2:    return ma;
      default: return ml;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input in_t v);
    hold = v.hold;  flush = v.flush;
    id_qa = v.qa;   id_qb = v.qb;   id_imm = v.imm;   id_pc4 = v.pc4;
    mem_alu = v.malu; mem_load = v.mload;
    id_fwda = v.fwda; id_fwdb = v.fwdb; id_aluc = v.aluc;
    id_aluimm = v.aluimm; id_shift = v.shift; id_jal = v.jal;
    id_wreg = v.wreg; id_m2reg = v.m2reg; id_wmem = v.wmem; id_rn = v.rn;
  endtask

  // Present one ID instruction, clock it, and advance the model alongside.
  task automatic cycle(input in_t v);
    m_t nm;
    drive(v);
    nm = m;
    if (!v.hold) begin
      nm.a = pick(v.fwda, v.qa, v.malu, v.mload);
      nm.b = pick(v.fwdb, v.qb, v.malu, v.mload);
      nm.imm = v.imm; nm.pc4 = v.pc4; nm.aluc = v.aluc;
      nm.shift = v.shift; nm.aluimm = v.aluimm; nm.rn = v.rn;
      nm.valid = !v.flush;
      nm.jal   = v.jal   && !v.flush;
      nm.wreg  = v.wreg  && !v.flush;
      nm.m2reg = v.m2reg && !v.flush;
      nm.wmem  = v.wmem  && !v.flush;
    end
    @(posedge clock);
    #1;
    m = nm;
  endtask

  function automatic in_t rnd_in();
    in_t r;
    r.hold   = ($urandom_range(0, 4) == 0);
    r.flush  = ($urandom_range(0, 4) == 0);
    r.qa = $urandom; r.qb = $urandom; r.imm = $urandom; r.pc4 = $urandom;
    r.malu = $urandom; r.mload = $urandom;
    r.fwda = 2'($urandom_range(0, 3));
    r.fwdb = 2'($urandom_range(0, 3));
    if (!m.valid && r.fwda == FWD_EX) r.fwda = FWD_RF;
    if (!m.valid && r.fwdb == FWD_EX) r.fwdb = FWD_RF;
    r.aluc   = ops[$urandom_range(0, 8)];
    r.aluimm = 1'($urandom_range(0, 1));
    r.shift  = ($urandom_range(0, 3) == 0);
    r.jal    = ($urandom_range(0, 5) == 0);
    r.wreg   = 1'($urandom_range(0, 1));
    r.m2reg  = 1'($urandom_range(0, 1));
    r.wmem   = 1'($urandom_range(0, 1));
    r.rn     = 5'($urandom_range(0, 31));
    return r;
  endfunction

  vec_t tbl [8];

  initial begin
    in_t t;
    m = '{default: '0};

    t = zero_in(); t.qa = 32'd5; t.imm = 32'hFFFF_FFFD; t.aluimm = 1'b1; t.aluc = ADD;
    t.wreg = 1'b1; t.rn = 5'd8;
    tbl[0] = mkv(t, 32'd5, 32'hFFFF_FFFD, 32'd2, 5'd8, 1'b1);
    t = zero_in(); t.shift = 1'b1; t.imm = 32'h0000_0100; t.qb = 32'h8000_0000; t.aluc = SRA;
    t.wreg = 1'b1; t.rn = 5'd9;
    tbl[1] = mkv(t, 32'd4, 32'h8000_0000, 32'hF800_0000, 5'd9, 1'b1);
    t = zero_in(); t.jal = 1'b1; t.pc4 = 32'hFFFF_FFFC; t.wreg = 1'b1;
    tbl[2] = mkv(t, 32'd0, 32'd0, 32'd0, 5'd31, 1'b1);
    // JAL with pc4 = -2 keeps ex_result at 2 while the forward source steps through all four.
    t = zero_in(); t.jal = 1'b1; t.pc4 = 32'hFFFF_FFFE; t.wreg = 1'b1;
    t.qa = 32'd1; t.malu = 32'd3; t.mload = 32'd4;
    for (int k = 0; k < 4; k++) begin
      t.fwda = 2'(k);
      tbl[3+k] = mkv(t, 32'(k + 1), 32'd0, 32'd2, 5'd31, 1'b1);
    end
    t = zero_in(); t.qa = 32'h0A; t.fwdb = FWD_MEM; t.malu = 32'h55; t.aluc = OR;
    t.wreg = 1'b1; t.rn = 5'd3;
    tbl[7] = mkv(t, 32'h0A, 32'h55, 32'h5F, 5'd3, 1'b1);

    reset = 1'b1;
    drive(zero_in());
    repeat (2) @(posedge clock);
    #1;
    chk("reset alu_a", alu_a, 32'd0);
    chk("reset alu_aluc", 32'(alu_aluc), 32'(ADD));
    chk("reset ex_valid", 32'(ex_valid), 32'd0);
    reset = 1'b0;

    foreach (tbl[k]) begin
      cycle(tbl[k].i);
      chk($sformatf("tbl%0d alu_a", k), alu_a, tbl[k].x_a);
      chk($sformatf("tbl%0d alu_b", k), alu_b, tbl[k].x_b);
      chk($sformatf("tbl%0d alu_aluc", k), 32'(alu_aluc), 32'(tbl[k].i.aluc));
      chk($sformatf("tbl%0d ex_result", k), ex_result, tbl[k].x_res);
      chk($sformatf("tbl%0d ex_rn", k), 32'(ex_rn), 32'(tbl[k].x_rn));
      chk($sformatf("tbl%0d ex_wreg", k), 32'(ex_wreg), 32'(tbl[k].x_wreg));
      chk($sformatf("tbl%0d ex_valid", k), 32'(ex_valid), 32'd1);
    end

    // Store, then hold+flush twice (hold wins), then flush alone.
    t = zero_in(); t.qa = 32'h100; t.qb = 32'h1234; t.imm = 32'd8; t.aluimm = 1'b1;
    t.aluc = ADD; t.wmem = 1'b1;
    cycle(t);
    chk("store ex_wmem", 32'(ex_wmem), 32'd1);
    chk("store ex_eb", ex_eb, 32'h1234);
    t = zero_in(); t.hold = 1'b1; t.flush = 1'b1; t.qb = 32'hDEAD; t.wreg = 1'b1;
    for (int k = 0; k < 2; k++) begin
      cycle(t);
      chk($sformatf("hold%0d ex_wmem", k), 32'(ex_wmem), 32'd1);
      chk($sformatf("hold%0d ex_eb", k), ex_eb, 32'h1234);
      chk($sformatf("hold%0d ex_result", k), ex_result, 32'h108);
      chk($sformatf("hold%0d ex_valid", k), 32'(ex_valid), 32'd1);
    end
    t.hold = 1'b0;
    cycle(t);
    chk("flush ex_wmem", 32'(ex_wmem), 32'd0);
    chk("flush ex_wreg", 32'(ex_wreg), 32'd0);
    chk("flush ex_valid", 32'(ex_valid), 32'd0);

    // Asynchronous reset between clock edges.
    t = zero_in(); t.qa = 32'd9; t.wreg = 1'b1; t.rn = 5'd7; t.aluc = SUB; t.wmem = 1'b1;
    cycle(t);
    chk("pre-reset ex_wreg", 32'(ex_wreg), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    chk("async reset ex_wreg", 32'(ex_wreg), 32'd0);
    chk("async reset ex_wmem", 32'(ex_wmem), 32'd0);
    chk("async reset ex_valid", 32'(ex_valid), 32'd0);
    chk("async reset ex_rn", 32'(ex_rn), 32'd0);
    chk("async reset alu_a", alu_a, 32'd0);
    chk("async reset alu_aluc", 32'(alu_aluc), 32'(ADD));
    chk("async reset ex_result", ex_result, 32'd0);
    m = '{default: '0};
    #1;
    reset = 1'b0;

    for (int k = 0; k < 400; k++) begin
      cycle(rnd_in());
      chk("rnd ex_valid", 32'(ex_valid), 32'(m.valid));
      chk("rnd ex_wreg", 32'(ex_wreg), 32'(m.wreg));
      chk("rnd ex_m2reg", 32'(ex_m2reg), 32'(m.m2reg));
      chk("rnd ex_wmem", 32'(ex_wmem), 32'(m.wmem));
      if (m.valid) begin
        chk("rnd alu_a", alu_a, m_opa());
        chk("rnd alu_b", alu_b, m_opb());
        chk("rnd alu_aluc", 32'(alu_aluc), 32'(m.aluc));
        chk("rnd ex_result", ex_result, m_res());
        chk("rnd ex_rn", 32'(ex_rn), m.jal ? 32'd31 : 32'(m.rn));
        chk("rnd ex_eb", ex_eb, m.b);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/pipe_id_ex.md
Name: pipe_id_ex

Overview:
ID/EX pipeline stage that sits directly upstream of the ALU and feeds its a, b and aluc inputs.
- Captures decoded controls and forwarded operands at the ID/EX boundary.
- Supports hold (stall) and flush (bubble insertion).
- Drives the ALU operand muxes: shift amount vs register, immediate vs register.
- Consumes the ALU result to form the EX-stage result (ALU s, or PC+8 on JAL) for EX/MEM and for forwarding.

Parameters:
XLEN, 32, datapath width (ALU is 32-bit; other values are unsupported)
RW, 5, register-number width

Ports:
clock  in  1  rising-edge clock
reset  in  1  asynchronous active-high reset
hold  in  1  keep all EX registers unchanged this cycle
flush  in  1  load a bubble instead of the ID instruction
id_qa  in  XLEN  register-file read data A
id_qb  in  XLEN  register-file read data B
id_fwda  in  2  operand A source: 00 qa, 01 ex_result, 10 mem_alu, 11 mem_load
id_fwdb  in  2  operand B source, same encoding
mem_alu  in  XLEN  MEM-stage ALU result
mem_load  in  XLEN  MEM-stage load data
id_imm  in  XLEN  sign/zero-extended immediate
id_pc4  in  XLEN  PC+4 of the ID instruction
id_aluc  in  4  ALU opcode
id_aluimm  in  1  B operand = immediate
id_shift  in  1  A operand = shamt
id_jal  in  1  result = PC+8, destination r31
id_wreg  in  1  writes a register
id_m2reg  in  1  load
id_wmem  in  1  store
id_rn  in  RW  destination register
alu_s  in  XLEN  ALU result (from ALU s)
alu_a  out  XLEN  to ALU a
alu_b  out  XLEN  to ALU b
alu_aluc  out  4  to ALU aluc
ex_result  out  XLEN  EX result
ex_wreg  out  1  registered
ex_m2reg  out  1  registered
ex_wmem  out  1  registered
ex_rn  out  RW  registered; forced to 31 when jal
ex_eb  out  XLEN  registered forwarded B, used as store data
ex_valid  out  1  registered; 1 = real instruction, 0 = bubble

Behaviour:
- Forwarding muxes are combinational at the ID side, before the register.
  - fa = id_fwda ? {ex_result, mem_alu, mem_load} : id_qa, selected by the encoding above; fb likewise.
  - ex_result feeds back combinationally from the current EX contents.
- Register update on clock rise, priority reset > hold > flush > load.
  - reset (async, any time): every registered field = 0, including ea, eb, imm, pc4, aluc, shift, aluimm, jal, wreg, m2reg, wmem, rn and valid.
  - Consequence of reset: alu_a = 0, alu_b = 0, alu_aluc = 0 (ADD), ex_result = alu_s (0 with a compliant ALU).
  - hold = 1: all fields retain their values; flush is ignored that cycle and must be reasserted by the hazard unit.
  - flush = 1, hold = 0: wreg, m2reg, wmem, jal and valid = 0; data fields take the ID values (don't-care); a bubble is never written to the register file or memory.
  - Otherwise: load fa, fb, all id_* controls and valid = 1.
- Latency: one cycle from ID capture to ALU operands; ALU is combinational, so ex_result is valid in the same EX cycle.
- Combinational EX outputs:
  - alu_a = e_shift ? {27'b0, e_imm[10:6]} : e_a
  - alu_b = e_aluimm ? e_imm : e_b
  - alu_aluc = e_aluc
  - ex_result = e_jal ? e_pc4 + 4 : alu_s
  - e_pc4 + 4 wraps modulo 2^32 (0xFFFF_FFFC + 4 = 0).
- ex_rn = e_jal ? 31 : e_rn.
- ex_eb = e_b (forwarded B, not the immediate).
- No combinational path from flush or hold to any output.

Decomposition:
- Shared package cpu_pkg holds:
  - FWD_RF = 2'b00, FWD_EX = 2'b01, FWD_MEM = 2'b10, FWD_LOAD = 2'b11
  - ALU opcode constants ADD/SUB/AND/OR/XOR/LUI/SLL/SRL/SRA, matching the ALU encoding
  - REG_RA = 31
- One natural sub-module: fwd_mux4, a 4:1 XLEN mux instantiated twice for A and B.

Test Plan:
- Reset reg/shift: assert reset mid-run with e_wreg = 1 -> all registered outputs 0 immediately, no clock needed; alu_aluc = 0; ex_valid = 0.
- Immediate path: qa = 5, imm = 0xFFFF_FFFD, aluimm = 1, aluc = ADD, wreg = 1, rn = 8 -> next cycle alu_a = 5, alu_b = 0xFFFF_FFFD; with a compliant ALU, ex_result = 2, ex_rn = 8.
- Shift path: shift = 1, imm = 0x0000_0100 (sa = 4), qb = 0x8000_0000, aluc = SRA -> alu_a = 4; with a compliant ALU, ex_result = 0xF800_0000.
- Forwarding, all four sources: qa = 1, ex_result = 2, mem_alu = 3, mem_load = 4 with fwda = 00/01/10/11 on successive cycles -> alu_a = 1, 2, 3, 4 respectively.
- JAL with wrap: jal = 1, pc4 = 0xFFFF_FFFC -> ex_result = 0, ex_rn = 31.
- Hold vs flush: load a store with wmem = 1, then hold = 1 and flush = 1 together for 2 cycles -> outputs unchanged, wmem = 1. Then flush alone -> ex_wmem = 0, ex_wreg = 0, ex_valid = 0.
